// File: rtl/dc_store_buffer_pkg.sv
// Shared types for the data-cache store buffer: the queued-store entry layout
// and the byte offset that separates a word address from a byte address.
package dc_store_buffer_pkg;

  localparam int SB_DATA_WIDTH = 32;
  localparam int SB_ADDR_WIDTH = 32;
  localparam int SB_DATA_SIZE  = SB_DATA_WIDTH / 8;

  // Low address bits below this index select a byte within a word.
  localparam int WORD_OFFSET = 2;

  typedef struct packed {
    logic [SB_ADDR_WIDTH-1:0] addr;
    logic [SB_DATA_WIDTH-1:0] data;
    logic [SB_DATA_SIZE-1:0]  byte_select;
    logic                     valid;
  } sb_entry_t;

endpackage

// File: rtl/dc_store_buffer_if.sv
// Bundle of the store, load and data-RAM port signals around the store buffer.
// The slave modport is the buffer itself; the master modport is its environment.
interface dc_store_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_SIZE  = DATA_WIDTH / 8
);

  logic                  i_st_valid;
  logic                  o_st_ready;
  logic [ADDR_WIDTH-1:0] i_st_addr;
  logic [DATA_WIDTH-1:0] i_st_data;
  logic [DATA_SIZE-1:0]  i_st_byte_select;

  logic                  i_ld_valid;
  logic                  o_ld_ready;
  logic [ADDR_WIDTH-1:0] i_ld_addr;
  logic                  o_ld_valid;
  logic [DATA_WIDTH-1:0] o_ld_data;

  logic                  o_sb_empty;

  logic                  o_dc_we;
  logic [ADDR_WIDTH-1:0] o_dc_addr;
  logic [DATA_WIDTH-1:0] o_dc_data;
  logic [DATA_SIZE-1:0]  o_dc_byte_select;
  logic                  i_dc_hit;
  logic [DATA_WIDTH-1:0] i_dc_data;

  modport slave (
    input  i_st_valid, i_st_addr, i_st_data, i_st_byte_select,
    input  i_ld_valid, i_ld_addr,
    input  i_dc_hit, i_dc_data,
    output o_st_ready, o_ld_ready, o_ld_valid, o_ld_data, o_sb_empty,
    output o_dc_we, o_dc_addr, o_dc_data, o_dc_byte_select
  );

  modport master (
    output i_st_valid, i_st_addr, i_st_data, i_st_byte_select,
    output i_ld_valid, i_ld_addr,
    output i_dc_hit, i_dc_data,
    input  o_st_ready, o_ld_ready, o_ld_valid, o_ld_data, o_sb_empty,
    input  o_dc_we, o_dc_addr, o_dc_data, o_dc_byte_select
  );

endinterface

// File: rtl/dc_store_buffer.sv
// Store buffer in front of a single-port data RAM: committed stores queue here
// and drain in order whenever a load does not claim the RAM port.
module dc_store_buffer
  import dc_store_buffer_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH = SB_DATA_WIDTH,
  parameter int OPTN_ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int OPTN_SB_DEPTH   = 4,
  parameter int DATA_SIZE       = OPTN_DATA_WIDTH / 8
) (
  input logic              clk,
  input logic              rst,
  dc_store_buffer_if.slave sb
);

  localparam int             IDX_W   = $clog2(OPTN_SB_DEPTH);
  localparam logic [IDX_W:0] PTR_ONE = 1;

  sb_entry_t entries [OPTN_SB_DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [IDX_W:0]   head;
  logic [IDX_W:0]   tail;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;

  logic full;
  logic empty;
  logic conflict;
  logic ld_accept;
  logic drain;
  logic enqueue;

  logic                       ld_valid_q;
  logic [OPTN_DATA_WIDTH-1:0] ld_data_q;
  logic [OPTN_DATA_WIDTH-1:0] head_data;
  logic [DATA_SIZE-1:0]       head_byte_select;

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];

  assign full  = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
  assign empty = (head == tail);

  // Any valid entry on the load's word blocks it, including the one leaving this cycle.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < OPTN_SB_DEPTH; i++) begin
      if (entries[i].valid &&
          entries[i].addr[OPTN_ADDR_WIDTH-1:WORD_OFFSET] ==
          sb.i_ld_addr[OPTN_ADDR_WIDTH-1:WORD_OFFSET]) begin
        conflict = 1'b1;
      end
    end
  end

  // A full buffer refuses loads so the drain always makes progress.
  assign sb.o_ld_ready = !full && !conflict && sb.i_dc_hit;
  assign ld_accept     = sb.i_ld_valid && sb.o_ld_ready;
  assign drain         = !rst && !empty && !ld_accept;
  assign enqueue       = sb.i_st_valid && !full;

  assign head_data        = entries[head_idx].data;
  assign head_byte_select = entries[head_idx].byte_select;

  assign sb.o_st_ready       = !full;
  assign sb.o_sb_empty       = empty;
  assign sb.o_dc_we          = drain;
  assign sb.o_dc_addr        = ld_accept ? sb.i_ld_addr : entries[head_idx].addr;
  assign sb.o_dc_data        = head_data;
  assign sb.o_dc_byte_select = head_byte_select;
  assign sb.o_ld_valid       = ld_valid_q;
  assign sb.o_ld_data        = ld_data_q;

  // Queue bookkeeping and the one-cycle registered load response.
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      for (int i = 0; i < OPTN_SB_DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      if (enqueue) begin
        entries[tail_idx] <= '{addr:        sb.i_st_addr,
                               data:        sb.i_st_data,
                               byte_select: sb.i_st_byte_select,
                               valid:       1'b1};
        tail <= tail + PTR_ONE;
      end
      if (drain) begin
        entries[head_idx].valid <= 1'b0;
        head <= head + PTR_ONE;
      end
      ld_valid_q <= ld_accept;
      if (ld_accept) begin
        ld_data_q <= sb.i_dc_data;
      end
    end
  end

endmodule

// File: tb/tb_dc_store_buffer.sv
// Scoreboard bench for dc_store_buffer: a cycle model predicts handshakes,
// RAM writes and load responses, and directed sequences exercise the corner cases.
module tb_dc_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  bs;
  } wr_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dc_store_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dc_store_buffer #(
    .OPTN_DATA_WIDTH(32),
    .OPTN_ADDR_WIDTH(32),
    .OPTN_SB_DEPTH  (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sb (bus)
  );

  wr_t         wrQ[$];
  logic [31:0] ldQ[$];
  logic [31:0] ram    [64];
  logic [31:0] refMem [64];
  int          compared   = 0;
  int          mismatched = 0;
  bit          monitorOn  = 1'b0;
  bit          ldInFlight = 1'b0;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                             input logic [3:0] bs);
    logic [31:0] r;
    r = oldW;
    for (int b = 0; b < 4; b++) if (bs[b]) r[8*b +: 8] = newW[8*b +: 8];
    return r;
  endfunction

  // Behavioural data RAM: combinational read, byte-masked write.
  always_comb bus.i_dc_data = ram[bus.o_dc_addr[7:2]];

  always @(posedge clk) begin
    if (bus.o_dc_we === 1'b1)
      ram[bus.o_dc_addr[7:2]] <= mergeBytes(ram[bus.o_dc_addr[7:2]], bus.o_dc_data, bus.o_dc_byte_select);
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Per-cycle model: wrQ mirrors the buffered stores, ldQ the responses owed.
  task automatic monitorCycle();
    bit  conflict;
    bit  expLdReady;
    bit  expWe;
    bit  stAccept;
    bit  ldAccept;
    int  count;
    wr_t w;
    count    = wrQ.size();
    conflict = 1'b0;
    foreach (wrQ[i]) if (wrQ[i].addr[31:2] == bus.i_ld_addr[31:2]) conflict = 1'b1;
    expLdReady = (count < DEPTH) && !conflict && (bus.i_dc_hit === 1'b1);
    ldAccept   = !rst && (bus.i_ld_valid === 1'b1) && expLdReady;
    expWe      = !rst && (count != 0) && !((bus.i_ld_valid === 1'b1) && expLdReady);
    stAccept   = !rst && (bus.i_st_valid === 1'b1) && (count < DEPTH);

    checkOutput("st_ready", bus.o_st_ready, count < DEPTH);
    checkOutput("sb_empty", bus.o_sb_empty, count == 0);
    checkOutput("ld_ready", bus.o_ld_ready, expLdReady);
    checkOutput("dc_we",    bus.o_dc_we,    expWe);
    checkOutput("ld_valid", bus.o_ld_valid, ldInFlight);
    if (ldInFlight && ldQ.size() > 0) checkOutput("ld_data", bus.o_ld_data, ldQ.pop_front());

    if (expWe) begin
      w = wrQ.pop_front();
      checkOutput("dc_addr", bus.o_dc_addr, w.addr);
      checkOutput("dc_data", bus.o_dc_data, w.data);
      checkOutput("dc_bs",   bus.o_dc_byte_select, w.bs);
      refMem[w.addr[7:2]] = mergeBytes(refMem[w.addr[7:2]], w.data, w.bs);
    end
    if (ldAccept) checkOutput("dc_addr_load", bus.o_dc_addr, bus.i_ld_addr);

    if (stAccept) wrQ.push_back('{bus.i_st_addr, bus.i_st_data, bus.i_st_byte_select});
    if (ldAccept) ldQ.push_back(refMem[bus.i_ld_addr[7:2]]);
    ldInFlight = ldAccept;

    if (rst) begin
      wrQ.delete();
      ldQ.delete();
      ldInFlight = 1'b0;
    end
  endtask

  always @(negedge clk) if (monitorOn) monitorCycle();

  task automatic applyStimulus(input bit stV, input logic [31:0] stA, input logic [31:0] stD,
                               input logic [3:0] stB, input bit ldV, input logic [31:0] ldA);
    bus.i_st_valid       = stV;
    bus.i_st_addr        = stA;
    bus.i_st_data        = stD;
    bus.i_st_byte_select = stB;
    bus.i_ld_valid       = ldV;
    bus.i_ld_addr        = ldA;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    repeat (n) nextCycle();
  endtask

  // Offer a store until it is taken, giving up after a fixed cycle budget.
  task automatic pushStore(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                           input bit ldV, input logic [31:0] ldA);
    int waited;
    waited = 0;
    applyStimulus(1'b1, a, d, b, ldV, ldA);
    while (bus.o_st_ready !== 1'b1 && waited < 20) begin
      nextCycle();
      #1;
      waited++;
    end
    if (waited >= 20) checkOutput("store_accept_timeout", 64'd0, 64'd1);
    nextCycle();
  endtask

  initial begin
    logic [3:0] bsTab [9];
    bsTab = '{4'b1111, 4'b0001, 4'b0011, 4'b1100, 4'b0000, 4'b1010, 4'b1111, 4'b0110, 4'b1000};

    for (int i = 0; i < 64; i++) begin
      ram[i]    = 32'h0;
      refMem[i] = 32'h0;
    end
    rst          = 1'b1;
    bus.i_dc_hit = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    monitorOn = 1'b1;
    #1;
    checkOutput("reset_st_ready", bus.o_st_ready, 1);
    checkOutput("reset_sb_empty", bus.o_sb_empty, 1);
    checkOutput("reset_dc_we",    bus.o_dc_we,    0);
    checkOutput("reset_ld_valid", bus.o_ld_valid, 0);
    checkOutput("reset_ld_data",  bus.o_ld_data,  0);
    nextCycle();

    // Single store into an empty buffer drains on the following cycle.
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0);
    checkOutput("first_store_no_bypass", bus.o_dc_we, 0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    checkOutput("first_store_we",   bus.o_dc_we,   1);
    checkOutput("first_store_addr", bus.o_dc_addr, 32'h10);
    checkOutput("first_store_data", bus.o_dc_data, 32'hDEADBEEF);
    nextCycle();
    checkOutput("first_store_empty_after", bus.o_sb_empty, 1);
    idleCycles(2);

    // Five stores while loads hold the RAM port: the fifth waits for a drain.
    for (int i = 0; i < 4; i++)
      pushStore(32'h40 + 32'(4 * i), 32'h5100_0000 + 32'(i), 4'b1111, 1'b1, 32'h80);
    applyStimulus(1'b1, 32'h50, 32'h5100_0004, 4'b1111, 1'b1, 32'h80);
    checkOutput("full_st_ready", bus.o_st_ready, 0);
    checkOutput("full_drain_priority", bus.o_dc_we, 1);
    pushStore(32'h50, 32'h5100_0004, 4'b1111, 1'b1, 32'h80);
    idleCycles(8);

    // Load to a pending store's word is held off until that store drains.
    applyStimulus(1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h22);
    checkOutput("conflict_ld_ready", bus.o_ld_ready, 0);
    checkOutput("conflict_drain_we", bus.o_dc_we, 1);
    nextCycle();
    checkOutput("conflict_cleared_ld_ready", bus.o_ld_ready, 1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    checkOutput("conflict_ld_valid", bus.o_ld_valid, 1);
    checkOutput("conflict_ld_data",  bus.o_ld_data, 32'hCAFEF00D);
    idleCycles(2);

    // Non-conflicting load goes first; the pending store drains right after.
    applyStimulus(1'b1, 32'h20, 32'h11223344, 4'b0101, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h30);
    checkOutput("noconf_ld_ready", bus.o_ld_ready, 1);
    checkOutput("noconf_we",       bus.o_dc_we,    0);
    checkOutput("noconf_addr",     bus.o_dc_addr,  32'h30);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    checkOutput("noconf_drain_we",   bus.o_dc_we,   1);
    checkOutput("noconf_drain_addr", bus.o_dc_addr, 32'h20);
    idleCycles(2);

    // A RAM miss blocks the load regardless of the buffer state.
    bus.i_dc_hit = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h34);
    checkOutput("miss_ld_ready", bus.o_ld_ready, 0);
    nextCycle();
    bus.i_dc_hit = 1'b1;
    idleCycles(1);

    // Nine stores with continuous drain wrap the pointers twice.
    for (int i = 0; i < 9; i++)
      pushStore(32'h60 + 32'(4 * i), 32'hA500_0000 + 32'(i * 32'h0101), bsTab[i], 1'b0, 32'h0);
    idleCycles(4);
    checkOutput("wrap_empty_after", bus.o_sb_empty, 1);

    // Randomised mix of stores and loads over a small address window.
    for (int i = 0; i < 80; i++) begin
      bus.i_dc_hit = ($urandom_range(0, 7) != 0);
      applyStimulus(($urandom_range(0, 1) == 1), 32'($urandom_range(0, 63)), $urandom,
                    4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0), 32'($urandom_range(0, 63)));
      nextCycle();
    end
    bus.i_dc_hit = 1'b1;
    idleCycles(8);

    // Reset with three pending stores and a load response owed.
    for (int i = 0; i < 3; i++)
      pushStore(32'hA0 + 32'(4 * i), 32'h7700_0000 + 32'(i), 4'b1111, 1'b1, 32'hF0);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hF0);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    checkOutput("rst_cycle_no_write", bus.o_dc_we, 0);
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ld_valid", bus.o_ld_valid, 0);
    checkOutput("post_rst_sb_empty", bus.o_sb_empty, 1);
    checkOutput("post_rst_dc_we",    bus.o_dc_we,    0);
    checkOutput("post_rst_st_ready", bus.o_st_ready, 1);
    idleCycles(6);
    checkOutput("final_sb_empty", bus.o_sb_empty, 1);

    monitorOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
